// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus-level constants and pointer sizing.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, NACK_W, WAIT
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

    function automatic int ptr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with SCL edge pulses and START/STOP detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic scl_d, sda_d;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing NUM_REGS byte registers through a pointer byte, with
// auto-increment, repeated START and NACK of foreign address or bad pointer.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR    = 7'h55,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = ptr_width(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             oe_q, oe_d, rw_q, rw_d, wr_en;
    logic [7:0]       shift_q, shift_d, new_byte;
    logic [6:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [NUM_REGS-1:0][7:0] regs;

    assign new_byte = {shift_q[6:0], sda_s};
    assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    shift_d = new_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            rw_d    = new_byte[0];
                            state_d = (new_byte[7:1] == SLV_ADDR) ? ADDR_ACK : WAIT;
                        end else if (state_q == PTR) begin
                            if (32'(new_byte) < NUM_REGS) begin
                                ptr_d   = new_byte[PTR_W-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                state_d = NACK_W;
                            end
                        end else begin
                            wr_en   = 1'b1;
                            ptr_d   = ptr_inc;
                            state_d = WDATA_ACK;
                        end
                    end
                end
                // cnt=0: first fall pulls SDA low; cnt=1: fall after the ACK pulse ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 4'd1;
                    end else begin
                        cnt_d = '0;
                        if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
                            state_d = RDATA;
                            tx_d    = regs[ptr_q][6:0];
                            oe_d    = ~regs[ptr_q][7];
                            ptr_d   = ptr_inc;
                        end else begin
                            state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                            oe_d    = 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        oe_d = ~tx_q[6];
                        tx_d = {tx_q[5:0], 1'b0};
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = '0;
                            state_d = RACK;
                        end
                    end
                end
                // cnt=1 records that the master ACKed and another byte is due.
                RACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            oe_d = 1'b0;
                        end else begin
                            cnt_d   = '0;
                            state_d = RDATA;
                            tx_d    = regs[ptr_q][6:0];
                            oe_d    = ~regs[ptr_q][7];
                            ptr_d   = ptr_inc;
                        end
                    end else if (scl_rise) begin
                        if (sda_s == I2C_ACK) cnt_d = 4'd1;
                        else                  state_d = WAIT;
                    end
                end
                NACK_W: if (scl_rise) state_d = WAIT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            oe_q      <= 1'b0;
            rw_q      <= 1'b0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            regs      <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oe_q      <= oe_d;
            rw_q      <= rw_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs[ptr_q] <= new_byte;
                wr_index    <= ptr_q;
                wr_data     <= new_byte;
            end
        end
    end

    assign sda_oe    = oe_q;
    assign regs_flat = regs;
    assign busy      = (state_q != IDLE);

    // SDA may only move while SCL is low, apart from the release on START/STOP.
    a_oe_stable: assert property (@(posedge clk) disable iff (reset)
        ($past(scl_s) && !$past(start_det) && !$past(stop_det)) |-> (oe_q == $past(oe_q)));

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bus-level bench: a bit-banged master, a byte-register reference model and
// scoreboard queues checked by monitors on the bus responses and write strobes.
module tb_i2c_slave_regfile;

    localparam int         NREG = 4;
    localparam logic [6:0] SLV  = 7'h55;

    typedef struct { string tag; logic [7:0] val; } resp_t;
    typedef struct { int idx; logic [7:0] data; } wr_t;

    logic clk = 1'b0, reset = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1;
    logic scl_i, sda_i, sda_oe, wr_strobe, busy;
    logic [8*NREG-1:0] regs_flat;
    logic [1:0] wr_index;
    logic [7:0] wr_data;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;   // open-drain wired-AND

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLV_ADDR(SLV), .NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index),
        .wr_data(wr_data), .busy(busy)
    );

    int total = 0, bad = 0, oe_hits = 0, hits0;
    bit quiet = 1'b0;
    resp_t exp_bus[$], obs_bus[$];
    wr_t   exp_wr[$];
    logic [7:0] mregs [NREG];
    int mptr;
    logic [7:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input string tag, input logic [7:0] v);
        resp_t r;
        r.tag = tag;
        r.val = v;
        return r;
    endfunction

    function automatic logic [8*NREG-1:0] model_flat();
        logic [8*NREG-1:0] f;
        for (int k = 0; k < NREG; k++) f[8*k +: 8] = mregs[k];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic s);
        sda_m = b;  tick(10);
        scl_m = 1'b1; tick(10);
        s = sda_i;  tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(20);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e_ack);
        logic s;
        exp_bus.push_back(mk("ack", {7'b0, e_ack}));
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        obs_bus.push_back(mk("ack", {7'b0, s}));
    endtask

    task automatic read_byte(input logic mack);
        logic s;
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, s);
            v = {v[6:0], s};
        end
        bit_io(mack, s);
        obs_bus.push_back(mk("rd", v));
    endtask

    // Reference: address must match, pointer must be in range, then bytes land at ptr++ mod NREG.
    task automatic do_write(input logic [6:0] a, input logic [7:0] p);
        bit am, pk;
        am = (a == SLV);
        pk = am && (int'(p) < NREG);
        bus_start();
        send_byte({a, 1'b0}, !am);
        send_byte(p, !pk);
        if (pk) mptr = int'(p);
        foreach (wq[i]) begin
            if (pk) begin
                exp_wr.push_back('{idx: mptr, data: wq[i]});
                mregs[mptr] = wq[i];
                mptr = (mptr + 1) % NREG;
            end
            send_byte(wq[i], !pk);
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        bit am;
        am = (a == SLV);
        bus_start();
        send_byte({a, 1'b1}, !am);
        for (int i = 0; i < n; i++) begin
            exp_bus.push_back(mk("rd", am ? mregs[mptr] : 8'hFF));
            if (am) mptr = (mptr + 1) % NREG;
            read_byte(i == n - 1);
        end
        chk("oe_after_nack", {31'b0, sda_oe}, 32'd0);
    endtask

    resp_t o_r, e_r;
    wr_t   ew;

    always @(negedge clk) begin
        if (obs_bus.size() > 0) begin
            o_r = obs_bus.pop_front();
            chk("bus_pending", {31'b0, exp_bus.size() > 0}, 32'd1);
            if (exp_bus.size() > 0) begin
                e_r = exp_bus.pop_front();
                chk(e_r.tag, {24'b0, o_r.val}, {24'b0, e_r.val});
            end
        end
    end

    always @(negedge clk) begin
        if (wr_strobe) begin
            chk("wr_pending", {31'b0, exp_wr.size() > 0}, 32'd1);
            if (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                chk("wr_index", {30'b0, wr_index}, ew.idx);
                chk("wr_data", {24'b0, wr_data}, {24'b0, ew.data});
            end
        end
    end

    always @(negedge clk) if (quiet && sda_oe) oe_hits++;

    initial begin
        #10000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    logic s;
    logic [6:0] ra;
    int kind, n;

    initial begin
        for (int k = 0; k < NREG; k++) mregs[k] = '0;
        mptr = 0;
        tick(5);
        chk("rst_oe", {31'b0, sda_oe}, 32'd0);
        chk("rst_regs", regs_flat, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobe", {31'b0, wr_strobe}, 32'd0);
        reset = 1'b0;
        tick(5);

        // write two bytes from pointer 1
        wq = {}; wq.push_back(8'h5A); wq.push_back(8'hC3);
        do_write(SLV, 8'h01);
        chk("t1_busy_mid", {31'b0, busy}, 32'd1);
        bus_stop();
        chk("t1_regs", regs_flat, model_flat());
        chk("t1_busy", {31'b0, busy}, 32'd0);

        // pointer wrap 3 -> 0, then read back from the wrapped pointer
        wq = {}; wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(SLV, 8'h03);
        bus_stop();
        chk("t2_regs", regs_flat, model_flat());
        do_read(SLV, 1);
        bus_stop();

        // pointer write, repeated START, two-byte read
        wq = {};
        do_write(SLV, 8'h02);
        do_read(SLV, 2);
        bus_stop();
        chk("t3_busy", {31'b0, busy}, 32'd0);

        // foreign address: target must stay silent
        quiet = 1'b1; hits0 = oe_hits;
        wq = {}; wq.push_back(8'h33);
        do_write(7'h50, 8'h01);
        chk("t4_busy_mid", {31'b0, busy}, 32'd1);
        bus_stop();
        quiet = 1'b0;
        chk("t4_quiet_oe", oe_hits - hits0, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        chk("t4_regs", regs_flat, model_flat());

        // out-of-range pointer
        wq = {}; wq.push_back(8'h99); wq.push_back(8'h98);
        do_write(SLV, 8'h07);
        bus_stop();
        chk("t5_regs", regs_flat, model_flat());

        // reset during the 4th data bit of a write
        bus_start();
        send_byte({SLV, 1'b0}, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) bit_io(1'b1, s);
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(5);
        reset = 1'b1; tick(3);
        chk("t6_oe", {31'b0, sda_oe}, 32'd0);
        chk("t6_regs", regs_flat, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < NREG; k++) mregs[k] = '0;
        mptr = 0;
        reset = 1'b0; tick(10);
        wq = {}; wq.push_back(8'h77);
        do_write(SLV, 8'h00);
        bus_stop();
        chk("t6_regs_after", regs_flat, model_flat());

        // randomized transactions against the model
        for (int it = 0; it < 20; it++) begin
            ra   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : SLV;
            kind = $urandom_range(0, 2);
            wq = {};
            if (kind < 2) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
                do_write(ra, 8'($urandom_range(0, 5)));
            end else begin
                do_read(ra, $urandom_range(1, 3));
            end
            bus_stop();
            chk("rnd_busy", {31'b0, busy}, 32'd0);
            chk("rnd_regs", regs_flat, model_flat());
        end

        tick(50);
        chk("bus_drained", exp_bus.size(), 32'd0);
        chk("wr_drained", exp_wr.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
